// File: rtl/xdisp_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xdisp_ctrl_if : CPU register bus between the address decoder and        |
// |                 the 7-segment display controller.                       |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
interface xdisp_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              sel;
   logic              we;
   logic [1:0]        addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   modport master (output sel, output we, output addr, output data_in, input data_out);
   modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface
`default_nettype wire

// File: rtl/xdisp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xdisp_ctrl : 4-digit multiplexed 7-segment display controller with      |
// |              double-buffered registers committed at frame boundaries.   |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
module xdisp_ctrl #(
   parameter int DATA_W      = 32,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYC     = 16
) (
   input  logic             clk,
   input  logic             rst,
   xdisp_ctrl_if.slave      bus,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp
);

   localparam int                CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  ON_END  = CNT_W'(REFRESH_DIV - GAP_CYC);
   localparam logic [8:0]        CTRL_RST = 9'h1F0;

   logic [15:0]      stg_value;
   logic [8:0]       stg_ctrl;
   logic [15:0]      disp_value;
   logic [8:0]       disp_ctrl;
   logic             pending;
   logic [1:0]       digit;
   logic [CNT_W-1:0] cnt;

   logic             wr_value;
   logic             wr_ctrl;
   logic             commit;
   logic             on_phase;
   logic             lit;
   logic [3:0]       nibble;
   logic [6:0]       seg_next;
   logic [DATA_W-1:0] rdata;
   logic             unused_bits;

   assign wr_value = bus.sel && bus.we && (bus.addr == 2'd0);
   assign wr_ctrl  = bus.sel && bus.we && (bus.addr == 2'd1);
   // Last gap cycle of digit 3 closes the frame.
   assign commit   = (cnt == CNT_MAX) && (digit == 2'd3);
   assign on_phase = (cnt < ON_END);
   assign lit      = on_phase && disp_ctrl[8] && disp_ctrl[4 + {30'd0, digit}];
   assign nibble   = disp_value[{digit, 2'b00} +: 4];
   assign unused_bits = ^bus.data_in[DATA_W-1:16];

   always_comb begin
      seg_next = 7'h7F;
      case (nibble)
         4'h0: seg_next = 7'h40;
         4'h1: seg_next = 7'h79;
         4'h2: seg_next = 7'h24;
         4'h3: seg_next = 7'h30;
         4'h4: seg_next = 7'h19;
         4'h5: seg_next = 7'h12;
         4'h6: seg_next = 7'h02;
         4'h7: seg_next = 7'h78;
         4'h8: seg_next = 7'h00;
         4'h9: seg_next = 7'h10;
         4'hA: seg_next = 7'h08;
         4'hB: seg_next = 7'h03;
         4'hC: seg_next = 7'h46;
         4'hD: seg_next = 7'h21;
         4'hE: seg_next = 7'h06;
         4'hF: seg_next = 7'h0E;
         default: seg_next = 7'h7F;
      endcase
   end

   // Reads expose the staging copy so software sees what it last wrote.
   always_comb begin
      rdata = '0;
      case (bus.addr)
         2'd0: rdata[15:0] = stg_value;
         2'd1: rdata[8:0]  = stg_ctrl;
         2'd2: rdata[2:0]  = {pending, digit};
         default: rdata = '0;
      endcase
   end
   assign bus.data_out = rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_value <= 16'h0000;
         stg_ctrl  <= CTRL_RST;
         pending   <= 1'b0;
      end else begin
         if (wr_value) stg_value <= bus.data_in[15:0];
         if (wr_ctrl)  stg_ctrl  <= bus.data_in[8:0];
         // A write on the commit edge keeps pending set for the next frame.
         if (wr_value || wr_ctrl) pending <= 1'b1;
         else if (commit)         pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_value <= 16'h0000;
         disp_ctrl  <= CTRL_RST;
      end else if (commit) begin
         disp_value <= stg_value;
         disp_ctrl  <= stg_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         digit <= 2'd0;
      end else if (cnt == CNT_MAX) begin
         cnt   <= '0;
         digit <= digit + 2'd1;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= lit ? ~(4'b0001 << digit) : 4'hF;
         seg <= seg_next;
         dp  <= lit ? ~disp_ctrl[digit] : 1'b1;
      end
   end

endmodule
`default_nettype wire
